// File: rtl/pinwheel_lsu_pkg.sv
// Shared types and constants for the pinwheel load/store unit.
//
// Contents:
//   LANES      - byte lanes per memory word (4)
//   size_e     - request size encoding (byte/half/word/illegal)
//   state_e    - access FSM states; ACC1 exists only when
//                PINWHEEL_LSU_SPLIT_EN is defined
//   misaligned - true when an access of the given size crosses a word
//
// Build option: PINWHEEL_LSU_SPLIT_EN enables the split (two-word) access path.
package pinwheel_lsu_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } size_e;

`ifdef PINWHEEL_LSU_SPLIT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    CAPT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    CAPT = 2'd3
  } state_e;
`endif

  // off + (1 << size) > 4; a byte never crosses a word, illegal size is
  // reported as an error elsewhere so it is not flagged here.
  function automatic logic misaligned(input logic [1:0] off, input size_e size);
    case (size)
      SIZE_HALF: misaligned = (off == 2'd3);
      SIZE_WORD: misaligned = (off != 2'd0);
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pinwheel_lsu_align.sv
// Combinational lane alignment for the pinwheel load/store unit.
//
// Ports:
//   off        - byte offset within the word (address bits [1:0])
//   size       - access size
//   sign_ext   - sign-extend the extracted load value
//   wdata      - right-justified store data
//   word_lo    - first memory word of the access (word0)
//   word_hi    - second memory word (word1), only meaningful for splits
//   lane_wdata - store data rotated left by 8*off onto the byte lanes
//   mask_lo    - byte strobes that land in the first word
//   mask_hi    - byte strobes that spill into the second word
//   load_data  - ({word_hi,word_lo} >> 8*off) truncated and extended
module pinwheel_lsu_align
  import pinwheel_lsu_pkg::*;
(
  input  logic [1:0]       off,
  input  size_e            size,
  input  logic             sign_ext,
  input  logic [31:0]      wdata,
  input  logic [31:0]      word_lo,
  input  logic [31:0]      word_hi,
  output logic [31:0]      lane_wdata,
  output logic [LANES-1:0] mask_lo,
  output logic [LANES-1:0] mask_hi,
  output logic [31:0]      load_data
);

  logic [4:0]         shamt;
  logic [5:0]         shamt_rev;
  logic [LANES-1:0]   bytes_en;
  logic [2*LANES-1:0] span;
  logic [31:0]        raw;

  assign shamt     = {off, 3'b000};
  assign shamt_rev = 6'd32 - {1'b0, shamt};

  // A shift by 32 yields zero, so off=0 degenerates cleanly to no rotation.
  assign lane_wdata = (wdata << shamt) | (wdata >> shamt_rev);

  always_comb begin
    bytes_en = 4'b1111;
    case (size)
      SIZE_BYTE: bytes_en = 4'b0001;
      SIZE_HALF: bytes_en = 4'b0011;
      default:   bytes_en = 4'b1111;
    endcase
  end

  // Strobes shifted past lane 3 belong to the next word.
  assign span    = {4'b0000, bytes_en} << off;
  assign mask_lo = span[LANES-1:0];
  assign mask_hi = span[2*LANES-1:LANES];

  assign raw = (word_lo >> shamt) | (word_hi << shamt_rev);

  always_comb begin
    load_data = raw;
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & raw[7]}}, raw[7:0]};
      SIZE_HALF: load_data = {{16{sign_ext & raw[15]}}, raw[15:0]};
      default:   load_data = raw;
    endcase
  end

endmodule

// File: rtl/pinwheel_lsu.sv
// Pinwheel load/store unit: turns byte-addressed byte/half/word requests
// into word accesses on a simple memory bus with a 1-cycle read latency.
//
// Ports:
//   clock, reset         - posedge clock, asynchronous active-high reset
//   req_*                - request; accepted when req_valid && req_ready
//                          (req_ready is high only in IDLE)
//   rsp_valid/rdata/error- registered one-cycle completion pulse, no
//                          backpressure; rdata is 0 for stores and errors
//   bus_addr/wdata/wmask - word address, lane-rotated data, write strobes
//                          (wmask 0000 means read)
//   bus_rdata            - read data, valid the cycle after a read address
//   dbg_state            - current FSM state, for observation only
//
// Handshake: a request transfers at a posedge where req_valid and req_ready
// are both high; it is latched at that edge and the unit stays busy until
// the cycle in which rsp_valid is high, when a new request may be accepted.
//
// Build option: PINWHEEL_LSU_SPLIT_EN splits misaligned accesses across two
// words (ACC0, ACC1); without it misaligned accesses are errors.
module pinwheel_lsu
  import pinwheel_lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_store,
  input  logic              req_signed,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wmask,
  input  logic [31:0]       bus_rdata,
  output logic [1:0]        dbg_state
);

  state_e             state, state_nxt;
  logic [ADDR_W-1:0]  word_q;
  logic [1:0]         off_q;
  size_e              size_q;
  logic [31:0]        wdata_q;
  logic               store_q;
  logic               signed_q;

  logic               acc_err;
  logic               rsp_fire;
  logic               rsp_err_nxt;
  logic [31:0]        rsp_data_nxt;

  logic [31:0]        lane_wdata;
  logic [LANES-1:0]   mask_lo, mask_hi;
  logic [31:0]        load_data;
  logic [31:0]        word_lo;

  // Address bits above the attached memory's byte range are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign dbg_state = state;

`ifdef PINWHEEL_LSU_SPLIT_EN
  logic        split;
  logic [31:0] word0_q;

  assign acc_err = (size_q == SIZE_ILLEGAL);
  assign split   = misaligned(off_q, size_q);

  // word0 of a split load arrives during ACC1; word1 arrives during CAPT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              word0_q <= '0;
    else if (state == ACC1) word0_q <= bus_rdata;
  end

  assign word_lo = split ? word0_q : bus_rdata;
`else
  logic unused_mask_hi;
  assign unused_mask_hi = ^mask_hi;

  assign acc_err = (size_q == SIZE_ILLEGAL) | misaligned(off_q, size_q);
  assign word_lo = bus_rdata;
`endif

  pinwheel_lsu_align u_align (
    .off        (off_q),
    .size       (size_q),
    .sign_ext   (signed_q),
    .wdata      (wdata_q),
    .word_lo    (word_lo),
    .word_hi    (bus_rdata),
    .lane_wdata (lane_wdata),
    .mask_lo    (mask_lo),
    .mask_hi    (mask_hi),
    .load_data  (load_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q   <= '0;
      off_q    <= 2'd0;
      size_q   <= SIZE_BYTE;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      word_q   <= req_addr[ADDR_W+1:2];
      off_q    <= req_addr[1:0];
      size_q   <= size_e'(req_size);
      wdata_q  <= req_wdata;
      store_q  <= req_store;
      signed_q <= req_signed;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_fire;
      rsp_error <= rsp_err_nxt;
      rsp_rdata <= rsp_data_nxt;
    end
  end

  // Bus outputs decode from state so that reset (state=IDLE) drives them
  // to zero immediately.
  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    bus_addr     = '0;
    bus_wdata    = '0;
    bus_wmask    = 4'b0000;
    rsp_fire     = 1'b0;
    rsp_err_nxt  = 1'b0;
    rsp_data_nxt = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACC0;
      end
      ACC0: begin
        bus_addr  = word_q;
        bus_wdata = lane_wdata;
        if (store_q && !acc_err) bus_wmask = mask_lo;
        if (acc_err) begin
          state_nxt   = IDLE;
          rsp_fire    = 1'b1;
          rsp_err_nxt = 1'b1;
`ifdef PINWHEEL_LSU_SPLIT_EN
        end else if (split) begin
          state_nxt = ACC1;
`endif
        end else if (store_q) begin
          state_nxt = IDLE;
          rsp_fire  = 1'b1;
        end else begin
          state_nxt = CAPT;
        end
      end
`ifdef PINWHEEL_LSU_SPLIT_EN
      ACC1: begin
        bus_addr  = word_q + ADDR_W'(1);
        bus_wdata = lane_wdata;
        if (store_q) begin
          bus_wmask = mask_hi;
          state_nxt = IDLE;
          rsp_fire  = 1'b1;
        end else begin
          state_nxt = CAPT;
        end
      end
`endif
      CAPT: begin
        state_nxt    = IDLE;
        rsp_fire     = 1'b1;
        rsp_data_nxt = load_data;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
